wptr_full_ctrl: RTL and testbench

- Write-side pointer and full-flag controller for the asynchronous FIFO. Sits directly upstream of the async pointer comparator.
- Owns the write binary counter and produces the Gray write pointer and the "one-ahead" Gray almost pointer that feed the comparator.
- Consumes the comparator's asynchronous afull_n / aalmost_full_n and turns them into a registered, overflow-safe wfull in the write domain.
- Also drives the write address and write enable for the dual-port RAM.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/flag_sync.sv | 24 ++
 rtl/wptr_full_ctrl.sv | 94 +++++++++
 tb/tb_wptr_full_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the asynchronous FIFO pointer/flag logic.
package fifo_pkg;

  localparam int unsigned DefaultN          = 4;
  localparam int unsigned DefaultSyncStages = 2;

  typedef enum logic [1:0] {
    NOT_FULL,
    FULL_HOLD,
    FULL_WAIT
  } wfull_state_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/flag_sync.sv
// Multi-stage single-bit synchronizer with a synchronous reset to a chosen value.
module flag_sync #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= {STAGES{RESET_VAL}};
    end else begin
      stages <= {stages[STAGES-2:0], d};
    end
  end

  assign q = stages[STAGES-1];

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side binary/Gray pointer owner and registered, overflow-safe full flag.
module wptr_full_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned n           = DefaultN,
  parameter int unsigned SYNC_STAGES = DefaultSyncStages
) (
  input  logic         wclk,
  input  logic         wrst,
  input  logic         winc,
  input  logic         afull_n,
  input  logic         aalmost_full_n,
  output logic         wen,
  output logic [n-1:0] waddr,
  output logic [n:0]   w_gptr,
  output logic [n:0]   w_galmost_ptr,
  output logic         wfull
);

  localparam int unsigned PW = n + 1;
  localparam int unsigned CW = $clog2(SYNC_STAGES + 1);
  localparam logic [n:0]    One      = PW'(1);
  localparam logic [n:0]    Two      = PW'(2);
  localparam logic [CW-1:0] HoldLast = CW'(SYNC_STAGES - 1);

  logic [n:0]    wbin;
  logic [n:0]    wbin_inc;
  logic [n:0]    wbin_inc2;
  logic [CW-1:0] hold_cnt;
  logic          afull_sync;
  logic          acc;
  wfull_state_t  state;

  flag_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_afull_sync (
    .clk (wclk),
    .rst (wrst),
    .d   (afull_n),
    .q   (afull_sync)
  );

  assign acc       = winc & ~wfull & ~wrst;
  assign wen       = acc;
  assign waddr     = wbin[n-1:0];
  assign wbin_inc  = wbin + One;
  assign wbin_inc2 = wbin + Two;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin          <= '0;
      w_gptr        <= '0;
      w_galmost_ptr <= PW'(bin2gray(32'd1));
      wfull         <= 1'b0;
      hold_cnt      <= '0;
      state         <= NOT_FULL;
    end else begin
      if (acc) begin
        wbin          <= wbin_inc;
        w_gptr        <= PW'(bin2gray(32'(wbin_inc)));
        w_galmost_ptr <= PW'(bin2gray(32'(wbin_inc2)));
      end
      case (state)
        NOT_FULL: begin
          // Predict full from the almost flag so the filling write itself raises wfull.
          if (acc && !aalmost_full_n) begin
            state    <= FULL_HOLD;
            wfull    <= 1'b1;
            hold_cnt <= '0;
          end
        end
        FULL_HOLD: begin
          // Wait until the synchronizer no longer holds the pre-write "not full" value.
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HoldLast) begin
            state <= FULL_WAIT;
          end
        end
        FULL_WAIT: begin
          if (afull_sync) begin
            state <= NOT_FULL;
            wfull <= 1'b0;
          end
        end
        default: begin
          state <= NOT_FULL;
          wfull <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl with a behavioural pointer comparator and occupancy model.
module tb_wptr_full_ctrl;

  localparam int N  = 4;
  localparam int SS = 2;

  logic         wclk;
  logic         wrst;
  logic         winc;
  logic         afull_n;
  logic         aalmost_full_n;
  logic         wen;
  logic [N-1:0] waddr;
  logic [N:0]   w_gptr;
  logic [N:0]   w_galmost_ptr;
  logic         wfull;

  logic [N:0]   rbin;
  logic [N:0]   r_gptr;
  logic [N:0]   full_pat;

  wptr_full_ctrl #(
    .n           (N),
    .SYNC_STAGES (SS)
  ) dut (
    .wclk           (wclk),
    .wrst           (wrst),
    .winc           (winc),
    .afull_n        (afull_n),
    .aalmost_full_n (aalmost_full_n),
    .wen            (wen),
    .waddr          (waddr),
    .w_gptr         (w_gptr),
    .w_galmost_ptr  (w_galmost_ptr),
    .wfull          (wfull)
  );

  // Comparator: write pointer is a full lap ahead of the read pointer.
  assign r_gptr         = rbin ^ (rbin >> 1);
  assign full_pat       = {~r_gptr[N:N-1], r_gptr[N-2:0]};
  assign afull_n        = (w_gptr != full_pat);
  assign aalmost_full_n = (w_galmost_ptr != full_pat);

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: counts of writes/reads and a time-stamped full flag.
  int m_wcnt = 0;
  int m_rcnt = 0;
  bit m_wfull = 0;
  int m_set_edge = 0;
  int k = 0;
  bit hist [0:4095];
  bit cur_rd;
  bit cur_winc;
  bit cur_rst;
  int dut_wen_cnt = 0;
  int model_acc_cnt = 0;
  int wraps = 0;
  logic [N:0] last_gptr = '0;
  int wfull_rises = 0;
  bit last_wfull = 0;

  typedef struct {
    bit         winc;
    bit         e_wen;
    logic [3:0] e_waddr;
    bit         e_wfull;
    logic [4:0] e_gptr;
  } vec_t;
  vec_t tbl [18];

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] ungray(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, k);
    end
  endtask

  task automatic drive(input bit wi, input bit rd, input bit rs);
    @(negedge wclk);
    winc     = wi;
    wrst     = rs;
    cur_winc = wi;
    cur_rd   = rd;
    cur_rst  = rs;
    #1;
  endtask

  task automatic check_model();
    logic [4:0] wb;
    logic [4:0] occ_dut;
    wb = 5'(m_wcnt);
    chk("wen",           wen,           32'(cur_winc & !m_wfull & !cur_rst));
    chk("waddr",         waddr,         32'(wb[3:0]));
    chk("w_gptr",        w_gptr,        32'(gray(wb)));
    chk("w_galmost_ptr", w_galmost_ptr, 32'(gray(wb + 5'd1)));
    chk("wfull",         wfull,         32'(m_wfull));
    occ_dut = ungray(w_gptr) - rbin;
    chk("no_overflow",   32'(occ_dut <= 5'd16), 32'd1);
    if (wen === 1'b1) dut_wen_cnt++;
    if (last_gptr == 5'b10000 && w_gptr == 5'b00000) wraps++;
    last_gptr = w_gptr;
    if (wfull === 1'b1 && !last_wfull) wfull_rises++;
    last_wfull = (wfull === 1'b1);
  endtask

  task automatic tick();
    int occ;
    bit acc;
    bit rd_ok;
    occ   = m_wcnt - m_rcnt;
    acc   = cur_winc && !m_wfull && !cur_rst;
    rd_ok = cur_rd && !cur_rst && occ > 0;
    if (cur_rst) begin
      m_wcnt  = 0;
      m_rcnt  = 0;
      m_wfull = 0;
      hist[k] = 1'b1;
      if (k > 0) hist[k-1] = 1'b1;
      rd_ok = 0;
    end else begin
      hist[k] = (occ != 16);
      if (acc && occ == 15) begin
        m_wfull    = 1;
        m_set_edge = k;
      end else if (m_wfull && k >= m_set_edge + SS + 1 && hist[k-SS]) begin
        m_wfull = 0;
      end
      if (acc) begin
        m_wcnt++;
        model_acc_cnt++;
      end
    end
    @(posedge wclk);
    #1;
    if (cur_rst) rbin = '0;
    else if (rd_ok) begin
      m_rcnt++;
      rbin = 5'(m_rcnt);
    end
    k++;
  endtask

  task automatic step(input bit wi, input bit rd, input bit rs);
    drive(wi, rd, rs);
    check_model();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int high_cnt;
    int cleared;
    int wr_phase;
    int base;

    winc = 1'b0;
    wrst = 1'b1;
    rbin = '0;
    for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 1'b1, 4'(i), 1'b0, gray(5'(i))};
    tbl[16] = '{1'b1, 1'b0, 4'd0, 1'b1, 5'b11000};
    tbl[17] = '{1'b1, 1'b0, 4'd0, 1'b1, 5'b11000};

    // Reset: outputs are unknown before the first edge, so only clock it.
    drive(0, 0, 1);
    tick();
    step(0, 0, 1);
    drive(0, 0, 0);
    chk("reset_wfull", wfull, 0);
    chk("reset_gptr", w_gptr, 0);
    chk("reset_galmost", w_galmost_ptr, 5'b00001);
    check_model();
    tick();

    // Fill to full from the table, then a dropped 17th/18th write.
    foreach (tbl[i]) begin
      drive(tbl[i].winc, 0, 0);
      chk("tbl_wen", wen, tbl[i].e_wen);
      chk("tbl_waddr", waddr, tbl[i].e_waddr);
      chk("tbl_wfull", wfull, tbl[i].e_wfull);
      chk("tbl_gptr", w_gptr, tbl[i].e_gptr);
      check_model();
      tick();
    end

    // One read: wfull must be held for the hold-off, then clear and accept waddr 0.
    high_cnt = 2;
    cleared  = 0;
    step(0, 1, 0);
    high_cnt++;
    for (int i = 0; i < 12 && !cleared; i++) begin
      drive(0, 0, 0);
      if (wfull === 1'b1) high_cnt++;
      else cleared = 1;
      check_model();
      tick();
    end
    chk("full_cleared", cleared, 1);
    chk("full_min_hold", 32'(high_cnt >= SS + 1), 1);
    drive(1, 0, 0);
    chk("refill_wen", wen, 1);
    chk("refill_waddr", waddr, 0);
    check_model();
    tick();

    // Random interleave until 40 more writes: pointer wraps 31 -> 0.
    base = model_acc_cnt;
    for (int i = 0; i < 600 && (model_acc_cnt - base) < 40; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    wr_phase = model_acc_cnt - base;
    chk("interleave_writes", wr_phase, 40);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("gptr_wrapped", 32'(wraps > 0), 1);

    // Stale almost-full: read lands on the same edge as the filling write.
    step(0, 0, 1);
    for (int i = 0; i < 15; i++) step(1, 0, 0);
    step(1, 1, 0);
    drive(0, 0, 0);
    chk("stale_set", wfull, 1);
    check_model();
    tick();
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    drive(0, 0, 0);
    chk("stale_clear", wfull, 0);
    chk("stale_gptr", w_gptr, 5'b11000);
    check_model();
    tick();

    // Reset while in the wait-for-not-full state.
    step(0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    drive(1, 0, 1);
    chk("rst_wen_full", wen, 0);
    check_model();
    tick();
    drive(1, 0, 1);
    chk("rst_wen_empty", wen, 0);
    check_model();
    tick();
    drive(0, 0, 0);
    chk("post_rst_wfull", wfull, 0);
    chk("post_rst_gptr", w_gptr, 0);
    chk("post_rst_galmost", w_galmost_ptr, 5'b00001);
    chk("post_rst_waddr", waddr, 0);
    check_model();
    tick();

    // winc held high with sparse reads: accepted writes track freed slots.
    dut_wen_cnt   = 0;
    model_acc_cnt = 0;
    wfull_rises   = 0;
    for (int i = 0; i < 300; i++) step(1, 1'($urandom_range(0, 3) == 0), 0);
    chk("hold_wen_count", dut_wen_cnt, model_acc_cnt);
    chk("hold_free_slots", model_acc_cnt, m_rcnt + (m_wcnt - m_rcnt));
    chk("hold_toggled", 32'(wfull_rises >= 2), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
